icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
// Direct-mapped, read-only instruction cache between the IF-stage program counter and a slower
// word-wide backing instruction memory. On a hit it returns the instruction in the same cycle.
// On a miss it asserts stall_o, which drives PCWrite/IF_ID write-disable, and refills the whole
// line through a req/ack memory port.
// PARAMETERS
// ADDR_W       32  byte-address width of pc_addr_i / mem_addr_o
// LINES        16  number of cache lines, power of 2, >=2
// WORDS_PER_LN  4  32-bit words per line, power of 2, >=2
// CNT_W        16  width of the hit/miss statistic counters
// PORTS
// clk_i          in   1       clock
// rst_n          in   1       synchronous active-low reset
// pc_addr_i      in   ADDR_W  fetch byte address; bits [1:0] are ignored
// fetch_en_i     in   1       a fetch is requested this cycle
// invalidate_i   in   1       clear all valid bits
// instr_o        out  32      instruction; meaningful only when instr_valid_o=1
// instr_valid_o  out  1       fetch_en_i & hit & state==IDLE (combinational)
// stall_o        out  1       fetch_en_i & !instr_valid_o, or state!=IDLE (combinational)
// mem_req_o      out  1       backing-memory read request
// mem_addr_o     out  ADDR_W  word-aligned refill address
// mem_ack_i      in   1       read data valid on mem_data_i; consumed only while mem_req_o=1
// mem_data_i     in   32      refill data
// hit_cnt_o      out  CNT_W   saturating count of hit cycles
// miss_cnt_o     out  CNT_W   saturating count of refills started
// BEHAVIOUR
// - Address split: OFF=log2(WORDS_PER_LN), IDX=log2(LINES), tag = pc_addr_i[ADDR_W-1:2+OFF+IDX].
// - Storage: data array, tag array and valid bits are registers; lookup is combinational.
// - Hit condition: valid[idx] & tag match.
// - Reset (rst_n=0 at a clock edge):
//   - all valid bits=0, state=IDLE, word counter=0;
//   - mem_req_o=0, mem_addr_o=0, both counters=0;
//   - instr_o is don't-care; instr_valid_o=0 when state is IDLE with no valid lines.
// - Reset in the middle of a refill abandons it; the line stays invalid.
// - FSM IDLE:
//   - fetch_en_i & hit: hit_cnt++ and stay in IDLE.
//   - fetch_en_i & miss: latch tag and index, word counter=0, miss_cnt++, go to REFILL.
//     mem_req_o=1 and mem_addr_o={tag,idx,0,2'b00} from the next cycle.
// - FSM REFILL:
//   - mem_req_o and mem_addr_o are held stable until mem_ack_i.
//   - On each ack: write mem_data_i to data[idx][cnt] and cnt++; mem_addr_o advances by 4.
//   - On the ack for word WORDS_PER_LN-1: mem_req_o=0, go to FILL.
// - FSM FILL (1 cycle): tag[idx]=latched tag, valid[idx]=1, go to IDLE.
//   The retried fetch then hits in IDLE.
// - Miss penalty with ack latency L (L>=1 cycles from req to ack):
//   1 + WORDS_PER_LN*L + 1 cycles, then the hit cycle.
// - The refill always completes, even if pc_addr_i or fetch_en_i changes (e.g. a branch flush).
//   The latched index and tag are used, never the live pc_addr_i.
// - invalidate_i:
//   - in IDLE: all valid bits are 0 next cycle. If fetch_en_i is also high, the lookup in that
//     same cycle still sees the old valid bits.
//   - during REFILL/FILL: the other lines are cleared, and FILL still sets the valid bit of
//     the line being refilled.
// - mem_ack_i while mem_req_o=0 is ignored.
// - Counters saturate at all-ones; they never wrap.
// - Same line requested during its own refill: stall until FILL is done; no second refill.
// STRUCTURE
// - Shared icache package: FSM state encoding (IDLE=2'd0, REFILL=2'd1, FILL=2'd2) and helper
//   constants for OFF/IDX/TAG widths.
// - One sub-module, icache_refill_ctrl: FSM, word counter, mem_req_o/mem_addr_o generation.
// - The top level keeps the arrays, the lookup and the counters.
// TESTING
// - Defaults, memory with L=2. Reset, then fetch 0x0000_0040 -> stall_o=1 for 1+4*2+1=10 cycles.
//   Expect mem_addr_o 0x40,0x44,0x48,0x4C, then instr_valid_o=1 with instr_o = word at 0x40.
//   miss_cnt_o=1.
// - Then fetch 0x44, 0x48, 0x4C back-to-back -> 3 hits with zero stall; hit_cnt_o=4.
// - Fetch 0x0000_0440 (same index 4, different tag) -> refill, line replaced.
//   Re-fetch 0x40 -> misses again.
// - Change pc_addr_i to 0x200 in the middle of a refill of 0x40 -> refill still completes for
//   0x40. Then 0x200 misses; 0x40 afterwards hits.
// - Assert rst_n=0 after the 2nd ack of a refill -> mem_req_o=0 and counters=0 next cycle.
//   Fetching 0x40 afterwards misses.
// - invalidate_i with fetch_en_i=1 on a valid line -> that cycle hits; the next fetch misses.
// - Also hold mem_ack_i=1 while mem_req_o=0 -> no array write occurs.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   state_e  : refill FSM encoding (IDLE / REFILL / FILL)
//   off_w    : word-offset field width for a given line length
//   idx_w    : index field width for a given line count
//   tag_w    : tag field width for a given address width and geometry
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_FILL   = 2'd2
  } state_e;

  // Byte-within-word bits of a fetch address; always ignored by the cache.
  localparam int unsigned BYTE_OFF_W = 2;

  function automatic int unsigned off_w(input int unsigned words_per_ln);
    return $clog2(words_per_ln);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned lines,
                                        input int unsigned words_per_ln);
    return addr_w - BYTE_OFF_W - off_w(words_per_ln) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refill controller for icache_direct_mapped.
// Owns the FSM, the word counter and the latched tag/index of the line being
// refilled, and generates the backing-memory request.
//   clk_i, rst_n   : clock, synchronous active-low reset
//   start_i        : miss detected in IDLE; begin a refill
//   start_tag_i    : tag of the missing fetch
//   start_idx_i    : index of the missing fetch
//   mem_ack_i      : memory data valid (only consumed while mem_req_o=1)
//   state_o        : current FSM state
//   mem_req_o      : memory read request
//   mem_addr_o     : word-aligned refill address
//   wr_en_o        : write mem_data into data[line_idx_o][wr_word_o]
//   wr_word_o      : word slot being written
//   line_idx_o     : index of the line being refilled
//   line_tag_o     : tag of the line being refilled
//   fill_o         : FILL cycle; commit tag and set the valid bit
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF_W  = 2,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = ADDR_W - BYTE_OFF_W - OFF_W - IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [TAG_W-1:0]  start_tag_i,
  input  logic [IDX_W-1:0]  start_idx_i,
  input  logic              mem_ack_i,
  output state_e            state_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              wr_en_o,
  output logic [OFF_W-1:0]  wr_word_o,
  output logic [IDX_W-1:0]  line_idx_o,
  output logic [TAG_W-1:0]  line_tag_o,
  output logic              fill_o
);

  localparam logic [OFF_W-1:0] LAST_WORD = '1;

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_REFILL;
          cnt_d   = '0;
          tag_d   = start_tag_i;
          idx_d   = start_idx_i;
        end
      end
      ST_REFILL: begin
        if (mem_ack_i) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) state_d = ST_FILL;
        end
      end
      ST_FILL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: all derived from registered state, so the request and address
  // stay stable for the whole wait on each word.
  always_comb begin
    mem_req_o  = (state_q == ST_REFILL);
    mem_addr_o = '0;
    if (mem_req_o) mem_addr_o = {tag_q, idx_q, cnt_q, 2'b00};
    wr_en_o    = mem_req_o & mem_ack_i;
    fill_o     = (state_q == ST_FILL);
  end

  assign state_o    = state_q;
  assign wr_word_o  = cnt_q;
  assign line_idx_o = idx_q;
  assign line_tag_o = tag_q;

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with same-cycle hit and
// whole-line refill from a word-wide req/ack backing memory.
//   clk_i, rst_n   : clock, synchronous active-low reset
//   pc_addr_i      : fetch byte address (bits [1:0] ignored)
//   fetch_en_i     : fetch requested this cycle
//   invalidate_i   : clear all valid bits
//   instr_o        : instruction (meaningful when instr_valid_o=1)
//   instr_valid_o  : fetch hit while idle
//   stall_o        : hold PC / IF-ID while a fetch cannot be served
//   mem_req_o, mem_addr_o, mem_ack_i, mem_data_i : backing-memory port
//   hit_cnt_o      : saturating count of hit cycles
//   miss_cnt_o     : saturating count of refills started
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINES        = 16,
  parameter int unsigned WORDS_PER_LN = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr_i,
  input  logic              fetch_en_i,
  input  logic              invalidate_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int unsigned OFF_W = off_w(WORDS_PER_LN);
  localparam int unsigned IDX_W = idx_w(LINES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, LINES, WORDS_PER_LN);
  localparam int unsigned IDX_LO = BYTE_OFF_W + OFF_W;
  localparam int unsigned TAG_LO = IDX_LO + IDX_W;

  // Address split of the live fetch address.
  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_bits;

  assign pc_off         = pc_addr_i[IDX_LO-1:BYTE_OFF_W];
  assign pc_idx         = pc_addr_i[TAG_LO-1:IDX_LO];
  assign pc_tag         = pc_addr_i[ADDR_W-1:TAG_LO];
  assign unused_pc_bits = ^pc_addr_i[BYTE_OFF_W-1:0];

  // Storage.
  logic [31:0]      data_arr [LINES][WORDS_PER_LN];
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [LINES-1:0] valid_q, valid_d;

  // Refill controller.
  state_e           state;
  logic             start;
  logic             wr_en;
  logic [OFF_W-1:0] wr_word;
  logic [IDX_W-1:0] line_idx;
  logic [TAG_W-1:0] line_tag;
  logic             fill;

  icache_refill_ctrl #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_refill_ctrl (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start),
    .start_tag_i (pc_tag),
    .start_idx_i (pc_idx),
    .mem_ack_i   (mem_ack_i),
    .state_o     (state),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .wr_en_o     (wr_en),
    .wr_word_o   (wr_word),
    .line_idx_o  (line_idx),
    .line_tag_o  (line_tag),
    .fill_o      (fill)
  );

  // Combinational lookup against the registered arrays.
  logic hit;
  logic idle;

  assign idle          = (state == ST_IDLE);
  assign hit           = valid_q[pc_idx] & (tag_arr[pc_idx] == pc_tag);
  assign instr_o       = data_arr[pc_idx][pc_off];
  assign instr_valid_o = fetch_en_i & hit & idle;
  assign stall_o       = (fetch_en_i & ~instr_valid_o) | ~idle;
  assign start         = fetch_en_i & ~hit & idle;

  // NOTE: the data and tag arrays are not reset; the valid bits alone decide
  // whether an entry is used, so resetting the storage would only cost area.
  always_ff @(posedge clk_i) begin
    if (wr_en) data_arr[line_idx][wr_word] <= mem_data_i;
    if (fill)  tag_arr[line_idx]           <= line_tag;
  end

  // Invalidate clears everything, but the line completing its refill in
  // this cycle is still marked valid.
  always_comb begin
    valid_d = valid_q;
    if (invalidate_i) valid_d = '0;
    if (fill)         valid_d[line_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Saturating statistics.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (instr_valid_o && hit_cnt_o != '1) hit_cnt_o  <= hit_cnt_o + CNT_W'(1);
      if (start && miss_cnt_o != '1)        miss_cnt_o <= miss_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped (default geometry, memory ack
// latency of 2 cycles). Memory word at byte address a is 0xC0DE_0000 | a[15:0].
module tb_icache_direct_mapped;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int LAT    = 2;
  localparam int MISS_STALL = 1 + 4 * LAT + 1;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] pc_addr_i;
  logic              fetch_en_i;
  logic              invalidate_i;
  logic [31:0]       instr_o;
  logic              instr_valid_o;
  logic              stall_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [31:0]       mem_data_i;
  logic [CNT_W-1:0]  hit_cnt_o;
  logic [CNT_W-1:0]  miss_cnt_o;

  icache_direct_mapped dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .pc_addr_i     (pc_addr_i),
    .fetch_en_i    (fetch_en_i),
    .invalidate_i  (invalidate_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .stall_o       (stall_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Backing memory: acks each requested word in its LAT-th cycle.
  // force_ack drives a stray ack regardless of mem_req_o.
  logic        force_ack  = 1'b0;
  logic [31:0] force_data = 32'h0;

  initial begin
    int wcnt;
    wcnt       = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      if (force_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = force_data;
        wcnt       = 0;
      end else if (mem_req_o) begin
        wcnt++;
        if (wcnt == LAT) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(mem_addr_o);
          wcnt       = 0;
        end else begin
          mem_ack_i = 1'b0;
        end
      end else begin
        mem_ack_i = 1'b0;
        wcnt      = 0;
      end
    end
  end

  // Accepted refill addresses of the most recent run_fetch.
  logic [31:0] ack_q[$];

  // Present a fetch and wait (bounded) until it is served; optionally
  // redirect the PC after switch_at stalled cycles.
  task automatic run_fetch(input logic [31:0] addr, input int exp_stall,
                           input logic [31:0] switch_addr, input int switch_at,
                           input string name);
    int n;
    @(negedge clk_i);
    pc_addr_i  = addr;
    fetch_en_i = 1'b1;
    ack_q.delete();
    #1;
    n = 0;
    while (stall_o && n < 200) begin
      if (mem_req_o && mem_ack_i) ack_q.push_back(mem_addr_o);
      @(negedge clk_i);
      n++;
      if (n == switch_at) pc_addr_i = switch_addr;
      #1;
    end
    check({name, " stall cycles"}, 64'(n), 64'(exp_stall));
    check({name, " instr_valid"}, 64'(instr_valid_o), 64'd1);
    check({name, " instr"}, 64'(instr_o), 64'(mem_word(pc_addr_i)));
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        fetch_en;
    logic        exp_valid;
    logic        exp_stall;
    logic [15:0] exp_hit;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] exp_addrs[$];
    int acks;
    int n;

    // Back-to-back fetches within line 0x40, idle cycles, then a re-hit.
    vecs[0] = '{32'h44, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[1] = '{32'h48, 1'b1, 1'b1, 1'b0, 16'd2};
    vecs[2] = '{32'h4E, 1'b1, 1'b1, 1'b0, 16'd3};  // byte bits ignored
    vecs[3] = '{32'h40, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[4] = '{32'h80, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[5] = '{32'h40, 1'b1, 1'b1, 1'b0, 16'd4};

    rst_n        = 1'b0;
    pc_addr_i    = '0;
    fetch_en_i   = 1'b0;
    invalidate_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("reset mem_req", 64'(mem_req_o), 64'd0);
    check("reset mem_addr", 64'(mem_addr_o), 64'd0);
    check("reset hit_cnt", 64'(hit_cnt_o), 64'd0);
    check("reset miss_cnt", 64'(miss_cnt_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset instr_valid", 64'(instr_valid_o), 64'd0);
    rst_n = 1'b1;

    // First miss on 0x40.
    run_fetch(32'h40, MISS_STALL, 32'h0, -1, "miss 0x40");
    exp_addrs = '{32'h40, 32'h44, 32'h48, 32'h4C};
    check("refill ack count", 64'(ack_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++)
      check("refill addr", 64'(ack_q[i]), 64'(exp_addrs[i]));
    check("miss_cnt after first miss", 64'(miss_cnt_o), 64'd1);

    // Table-driven hit / idle vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      pc_addr_i  = vecs[i].pc;
      fetch_en_i = vecs[i].fetch_en;
      #1;
      check("vec instr_valid", 64'(instr_valid_o), 64'(vecs[i].exp_valid));
      check("vec stall", 64'(stall_o), 64'(vecs[i].exp_stall));
      check("vec hit_cnt", 64'(hit_cnt_o), 64'(vecs[i].exp_hit));
      if (vecs[i].exp_valid)
        check("vec instr", 64'(instr_o), 64'(mem_word({vecs[i].pc[31:2], 2'b00})));
    end

    // Conflict on index 4: 0x440 replaces 0x40, which then misses again.
    run_fetch(32'h440, MISS_STALL, 32'h0, -1, "miss 0x440");
    check("0x440 first refill addr", 64'(ack_q.size() > 0 ? ack_q[0] : 32'hFFFF_FFFF), 64'h440);
    run_fetch(32'h40, MISS_STALL, 32'h0, -1, "re-miss 0x40");
    check("miss_cnt after conflict", 64'(miss_cnt_o), 64'd3);

    // Redirect PC mid-refill: the 0x40 refill finishes, then 0x200 misses.
    run_fetch(32'h440, MISS_STALL, 32'h0, -1, "evict 0x40");
    run_fetch(32'h40, 2 * MISS_STALL, 32'h200, 3, "redirect to 0x200");
    exp_addrs = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h200, 32'h204, 32'h208, 32'h20C};
    check("redirect ack count", 64'(ack_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < ack_q.size(); i++)
      check("redirect refill addr", 64'(ack_q[i]), 64'(exp_addrs[i]));
    check("miss_cnt after redirect", 64'(miss_cnt_o), 64'd6);
    run_fetch(32'h40, 0, 32'h0, -1, "0x40 hit after redirect");

    // Invalidate together with a fetch: that cycle still hits.
    @(negedge clk_i);
    pc_addr_i    = 32'h40;
    fetch_en_i   = 1'b1;
    invalidate_i = 1'b1;
    #1;
    check("invalidate cycle hit", 64'(instr_valid_o), 64'd1);
    check("invalidate cycle stall", 64'(stall_o), 64'd0);
    @(negedge clk_i);
    invalidate_i = 1'b0;
    #1;
    check("after invalidate miss", 64'(stall_o), 64'd1);
    check("after invalidate valid", 64'(instr_valid_o), 64'd0);

    // Let two words of this refill land, then reset.
    acks = 0;
    n    = 0;
    while (acks < 2 && n < 50) begin
      @(negedge clk_i);
      #1;
      if (mem_req_o && mem_ack_i) acks++;
      n++;
    end
    check("acks before reset", 64'(acks), 64'd2);
    @(negedge clk_i);
    rst_n      = 1'b0;
    fetch_en_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("mid-refill reset mem_req", 64'(mem_req_o), 64'd0);
    check("mid-refill reset mem_addr", 64'(mem_addr_o), 64'd0);
    check("mid-refill reset hit_cnt", 64'(hit_cnt_o), 64'd0);
    check("mid-refill reset miss_cnt", 64'(miss_cnt_o), 64'd0);
    rst_n = 1'b1;
    run_fetch(32'h40, MISS_STALL, 32'h0, -1, "miss after reset");
    check("refill restarts at word 0", 64'(ack_q.size() > 0 ? ack_q[0] : 32'hFFFF_FFFF), 64'h40);
    check("miss_cnt after reset", 64'(miss_cnt_o), 64'd1);

    // Stray acks while idle must not write the arrays.
    @(negedge clk_i);
    fetch_en_i = 1'b0;
    force_data = 32'hDEAD_BEEF;
    force_ack  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      check("stray ack mem_req", 64'(mem_req_o), 64'd0);
    end
    force_ack = 1'b0;
    @(negedge clk_i);
    pc_addr_i  = 32'h40;
    fetch_en_i = 1'b1;
    #1;
    check("hit after stray ack", 64'(instr_valid_o), 64'd1);
    check("data after stray ack", 64'(instr_o), 64'(mem_word(32'h40)));
    check("miss_cnt after stray ack", 64'(miss_cnt_o), 64'd1);

    @(negedge clk_i);
    fetch_en_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
